// File: rtl/snn_mac_pkg.sv
// Shared definitions for the binary-weight serial MAC: weight encoding,
// beat-sum width helper and the saturating clamp used by the accumulator.
package snn_mac_pkg;

  localparam logic W_NEG = 1'b0;
  localparam logic W_POS = 1'b1;

  // Signed width able to hold -lanes..+lanes.
  function automatic int beat_sum_width(input int lanes);
    return $clog2(lanes) + 2;
  endfunction

  // Clamp a wide signed value into the signed range of `width` bits.
  function automatic logic signed [63:0] sat_acc(input logic signed [63:0] value,
                                                 input int unsigned      width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/binary_lane_adder.sv
// Combinational per-lane binary-weight product and sum for one beat.
module binary_lane_adder
  import snn_mac_pkg::*;
#(
  parameter int LANES = 8
) (
  input  logic [LANES-1:0]                       x,
  input  logic [LANES-1:0]                       w,
  output logic signed [beat_sum_width(LANES)-1:0] beat_sum
);

  localparam int SUM_W = beat_sum_width(LANES);

  always_comb begin
    beat_sum = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (x[i]) begin
        case (w[i])
          W_POS: beat_sum = beat_sum + SUM_W'(1);
          W_NEG: beat_sum = beat_sum - SUM_W'(1);
        endcase
      end
    end
  end

endmodule

// File: rtl/binary_mac_serial.sv
// Time-multiplexed binary-weight MAC: accumulates LANES synapses per beat,
// adds a signed bias and hands one saturated sum per vector downstream.
module binary_mac_serial
  import snn_mac_pkg::*;
#(
  parameter int N_INPUTS = 64,
  parameter int LANES    = 8,
  parameter int BIAS_W   = 8,
  parameter int ACC_W    = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES-1:0]         x_in,
  input  logic [LANES-1:0]         w_in,
  input  logic signed [BIAS_W-1:0] bias,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [ACC_W-1:0]  y_out,
  output logic                     busy
);

  localparam int BEATS = N_INPUTS / LANES;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int SUM_W = beat_sum_width(LANES);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t                     state_q, state_d;
  logic [CNT_W-1:0]           beat_cnt;
  logic signed [ACC_W-1:0]    acc;
  logic signed [SUM_W-1:0]    beat_sum;
  logic signed [ACC_W-1:0]    acc_nxt;
  logic signed [63:0]         base;
  logic                       accept;
  logic                       first_beat;
  logic                       last_beat;

  binary_lane_adder #(.LANES(LANES)) u_lane_adder (
    .x        (x_in),
    .w        (w_in),
    .beat_sum (beat_sum)
  );

  assign out_valid  = (state_q == HOLD);
  assign in_ready   = ~out_valid | out_ready;
  assign accept     = in_valid & in_ready;
  assign busy       = (beat_cnt != '0);
  assign first_beat = (beat_cnt == '0);
  assign last_beat  = (beat_cnt == CNT_W'(BEATS - 1));

  // Wide signed arithmetic cannot overflow, so clamping it matches an ACC_W+1 sum.
  always_comb begin
    base    = first_beat ? 64'(bias) : 64'(acc);
    acc_nxt = ACC_W'(sat_acc(base + 64'(beat_sum), ACC_W));
  end

  always_comb begin
    state_d = state_q;
    if (accept && last_beat)
      state_d = HOLD;
    else if (state_q == HOLD && out_ready)
      state_d = ACCUM;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ACCUM;
      beat_cnt <= '0;
      acc      <= '0;
      y_out    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        acc      <= acc_nxt;
        beat_cnt <= last_beat ? '0 : beat_cnt + CNT_W'(1);
        if (last_beat)
          y_out <= acc_nxt;
      end
    end
  end

endmodule

// File: tb/tb_binary_mac_serial.sv
// Directed + random bench for binary_mac_serial with a result scoreboard;
// a second instance covers the single-beat (LANES=N_INPUTS) configuration.
module tb_binary_mac_serial;

  logic clk = 1'b0;
  logic reset;

  logic              in_valid, in_ready, out_valid, out_ready, busy;
  logic [7:0]        x_in, w_in;
  logic signed [7:0] bias, y_out;

  logic              v1, ir1, ov1, or1, busy1;
  logic [63:0]       x1, w1;
  logic signed [7:0] b1, y1;

  int q[$];
  int q1[$];
  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  binary_mac_serial #(.N_INPUTS(64), .LANES(8), .BIAS_W(8), .ACC_W(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .x_in(x_in), .w_in(w_in), .bias(bias), .out_valid(out_valid),
    .out_ready(out_ready), .y_out(y_out), .busy(busy)
  );

  binary_mac_serial #(.N_INPUTS(64), .LANES(64), .BIAS_W(8), .ACC_W(8)) dut1 (
    .clk(clk), .reset(reset), .in_valid(v1), .in_ready(ir1),
    .x_in(x1), .w_in(w1), .bias(b1), .out_valid(ov1),
    .out_ready(or1), .y_out(y1), .busy(busy1)
  );

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Reference: signed sum of +/-1 products per beat, clamped after every beat.
  function automatic int model(input int b, input logic [63:0] xv,
                               input logic [63:0] wv, input int lanes);
    int a = b;
    for (int i = 0; i < 64 / lanes; i++) begin
      int s = 0;
      for (int j = 0; j < lanes; j++)
        if (xv[i*lanes+j]) s += wv[i*lanes+j] ? 1 : -1;
      a += s;
      if (a > 127) a = 127;
      if (a < -128) a = -128;
    end
    return a;
  endfunction

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (q.size() == 0) chk("sb_unexpected_result", q.size(), 1);
      else chk("y_out", y_out, q.pop_front());
    end
    if (!reset && ov1 && or1) begin
      if (q1.size() == 0) chk("sb1_unexpected_result", q1.size(), 1);
      else chk("y_out_beats1", y1, q1.pop_front());
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic beat(input logic [7:0] x, input logic [7:0] w,
                      input logic signed [7:0] b, output int waits);
    in_valid = 1'b1;
    x_in = x;
    w_in = w;
    bias = b;
    waits = 0;
    @(negedge clk);
    while (!in_ready && waits < 40) begin
      @(negedge clk);
      waits++;
    end
    chk("beat_accept", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    x_in = 8'($urandom);
    w_in = 8'($urandom);
    bias = 8'($urandom);
  endtask

  task automatic send_vec(input logic signed [7:0] b, input logic [63:0] xv,
                          input logic [63:0] wv, input int expv, input int max_gap);
    int wt;
    q.push_back(expv);
    for (int i = 0; i < 8; i++) begin
      idle($urandom_range(0, max_gap));
      // bias on later beats is garbage; only the first beat's bias counts
      beat(xv[i*8+:8], wv[i*8+:8], (i == 0) ? b : 8'($urandom), wt);
    end
  endtask

  initial begin
    int wt;
    logic signed [7:0] rb;
    logic [63:0] rx, rw;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    x_in = '0; w_in = '0; bias = '0;
    v1 = 1'b0; or1 = 1'b1; x1 = '0; w1 = '0; b1 = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_y_out", y_out, 0);
    chk("rst_out_valid_b1", ov1, 0);
    @(posedge clk); #1;

    // back-to-back all +1: result appears one cycle after beat 8, for one cycle
    send_vec(8'sd0, '1, '1, 64, 0);
    chk("lat_out_valid_set", out_valid, 1);
    @(posedge clk); #1;
    chk("lat_out_valid_clear", out_valid, 0);

    send_vec(8'sd3, '1, '0, -61, 1);
    send_vec(-8'sd5, '0, $urandom, -5, 1);
    send_vec(8'sd100, '1, '1, 127, 1);
    send_vec(-8'sd100, '1, '0, -128, 1);
    send_vec(8'sd120, '1, {8'h00, {56{1'b1}}}, 119, 0);
    idle(2);

    // backpressure: result held for 5 cycles while beats are offered
    out_ready = 1'b0;
    send_vec(8'sd0, '1, '1, 64, 0);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; x_in = 8'hff; w_in = 8'h00; bias = 8'sd7;
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_y_out", y_out, 64);
      chk("bp_busy", busy, 0);
      @(posedge clk); #1;
    end
    q.push_back(41);
    out_ready = 1'b1;
    beat(8'hff, 8'hff, 8'sd5, wt);
    chk("bp_release_waits", wt, 0);
    chk("bp_release_busy", busy, 1);
    chk("bp_release_out_valid", out_valid, 0);
    for (int i = 0; i < 7; i++) beat(8'h0f, 8'h0f, 8'($urandom), wt);
    idle(2);

    // reset mid-vector discards the partial sum
    for (int i = 0; i < 3; i++) beat(8'hff, 8'hff, 8'sd50, wt);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_out_valid", out_valid, 0);
    q.push_back(0);
    for (int i = 0; i < 7; i++) beat(8'hff, 8'haa, 8'sd0, wt);
    chk("midrst_not_done_7", out_valid, 0);
    beat(8'hff, 8'haa, 8'($urandom), wt);
    chk("midrst_done_8", out_valid, 1);
    idle(2);

    for (int n = 0; n < 6; n++) begin
      rb = 8'($urandom);
      rx = {$urandom, $urandom};
      rw = {$urandom, $urandom};
      send_vec(rb, rx, rw, model(int'(rb), rx, rw, 8), 2);
    end
    idle(3);

    // single-beat configuration: one result per cycle while streaming
    for (int k = 0; k < 6; k++) begin
      v1 = 1'b1;
      b1 = 8'($urandom);
      x1 = {$urandom, $urandom};
      w1 = (k == 0) ? '1 : {$urandom, $urandom};
      if (k == 0) b1 = 8'sd100;
      q1.push_back(model(int'(b1), x1, w1, 64));
      @(negedge clk);
      if (k > 0) chk("stream_out_valid", ov1, 1);
      chk("stream_in_ready", ir1, 1);
      @(posedge clk); #1;
    end
    v1 = 1'b0;
    @(negedge clk);
    chk("stream_last_valid", ov1, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("stream_drained", ov1, 0);

    idle(3);
    chk("sb_drain", q.size(), 0);
    chk("sb1_drain", q1.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
